// File: rtl/adc0804_responder_pkg.sv
// Shared definitions for the ADC0804-style responder: FSM encoding, default
// geometry and the saturating conversion-counter helper.
package adc0804_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_CONV_CYCLES = 64;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int CNT_W           = 8;

  // Counter never wraps: it parks at the conversion length.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    if (v >= lim) begin
      return lim;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/adc0804_responder_if.sv
// Parallel ADC handshake bundle; the controller is the master, the
// converter (responder) is the slave.
interface adc0804_responder_if #(
  parameter int DATA_W = 8
);
  logic              cs_n;
  logic              wr_n;
  logic              rd_n;
  logic              adc_clk;
  logic [DATA_W-1:0] sample_in;
  logic              intr_n;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic              busy;

  modport master (
    output cs_n, wr_n, rd_n, adc_clk, sample_in,
    input  intr_n, data_out, data_oe, busy
  );

  modport slave (
    input  cs_n, wr_n, rd_n, adc_clk, sample_in,
    output intr_n, data_out, data_oe, busy
  );
endinterface

// File: rtl/adc0804_responder_sync_ff.sv
// Multi-flop synchronizer for one asynchronous control pin, with a
// configurable reset level so strobes come out of reset inactive.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sr_q;

  // Shift the pin level through the synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= {STAGES{RST_VAL}};
    end else begin
      sr_q <= {sr_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sr_q[STAGES-1];

endmodule

// File: rtl/adc0804_responder.sv
// Device side of the cs_n/wr_n/rd_n/intr_n ADC handshake: arms on a write,
// latches the sample when wr_n returns high, counts adc_clk edges, then flags.
module adc0804_responder
  import adc0804_responder_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CONV_CYCLES = DEF_CONV_CYCLES,
  parameter int SYNC_STAGES = SYNC_STAGES_MIN
) (
  input logic                clk,
  input logic                rst_n,
  adc0804_responder_if.slave bus
);

  localparam logic [CNT_W-1:0] CONV_CNT = CNT_W'(CONV_CYCLES);

  logic cs_s, wr_s, rd_s, adc_s;
  logic cs_prev_q, wr_prev_q, rd_prev_q, adc_prev_q;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] data_out_q;
  logic              data_oe_q;
  logic              intr_n_q;
  logic              busy_q;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d_i(bus.cs_n), .q_o(cs_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_wr (
    .clk(clk), .rst_n(rst_n), .d_i(bus.wr_n), .q_o(wr_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rd (
    .clk(clk), .rst_n(rst_n), .d_i(bus.rd_n), .q_o(rd_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_adc (
    .clk(clk), .rst_n(rst_n), .d_i(bus.adc_clk), .q_o(adc_s)
  );

  // Previous synchronized levels for edge and window-transition detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_prev_q  <= 1'b1;
      wr_prev_q  <= 1'b1;
      rd_prev_q  <= 1'b1;
      adc_prev_q <= 1'b0;
    end else begin
      cs_prev_q  <= cs_s;
      wr_prev_q  <= wr_s;
      rd_prev_q  <= rd_s;
      adc_prev_q <= adc_s;
    end
  end

  logic wr_win, wr_win_prev, wr_open, wr_rise, cs_rise;
  logic rd_win, rd_win_prev, rd_open, adc_rise;

  assign wr_win      = ~cs_s & ~wr_s;
  assign wr_win_prev = ~cs_prev_q & ~wr_prev_q;
  assign wr_open     = wr_win & ~wr_win_prev;
  assign wr_rise     = wr_s & ~wr_prev_q;
  assign cs_rise     = cs_s & ~cs_prev_q;
  assign rd_win      = ~cs_s & ~rd_s;
  assign rd_win_prev = ~cs_prev_q & ~rd_prev_q;
  assign rd_open     = rd_win & ~rd_win_prev;
  assign adc_rise    = adc_s & ~adc_prev_q;

  // Conversion FSM with registered handshake outputs; later assignments win,
  // so a new write or a completion overrides the read-side intr_n release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      hold_q     <= '0;
      result_q   <= '0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      intr_n_q   <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      data_oe_q <= rd_win;
      if (rd_win) begin
        data_out_q <= result_q;
      end
      if (rd_open) begin
        intr_n_q <= 1'b1;
      end

      if (wr_open) begin
        state_q  <= ST_ARMED;
        cnt_q    <= 8'd0;
        intr_n_q <= 1'b1;
        busy_q   <= 1'b1;
      end else begin
        case (state_q)
          ST_ARMED: begin
            if (wr_rise) begin
              state_q <= ST_CONVERT;
              hold_q  <= bus.sample_in;
              cnt_q   <= 8'd0;
            end else if (cs_rise) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
          ST_CONVERT: begin
            if (cnt_q == CONV_CNT) begin
              state_q  <= ST_DONE;
              result_q <= hold_q;
              intr_n_q <= 1'b0;
              busy_q   <= 1'b0;
            end else if (adc_rise) begin
              cnt_q <= sat_inc(cnt_q, CONV_CNT);
            end
          end
          default: begin
            state_q <= state_q;
          end
        endcase
      end
    end
  end

  assign bus.intr_n   = intr_n_q;
  assign bus.data_out = data_out_q;
  assign bus.data_oe  = data_oe_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_adc0804_responder.sv
// Randomized transaction-level bench for adc0804_responder: a small model
// tracks the last completed result and the expected flag levels.
module tb_adc0804_responder;

  localparam int DW   = 8;
  localparam int CONV = 64;

  logic clk = 1'b0;
  logic rst_n;
  int   adc_cnt  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [DW-1:0] m_result;

  adc0804_responder_if #(.DATA_W(DW)) bus_if ();

  adc0804_responder #(
    .DATA_W(DW), .CONV_CYCLES(CONV), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if)
  );

  always #5 clk = ~clk;

  // adc_clk: 80 ns period, rising edges at 2 + 80k ns (never on a clk edge)
  initial begin
    bus_if.adc_clk = 1'b0;
    #2;
    forever begin
      bus_if.adc_clk = 1'b1;
      #40;
      bus_if.adc_clk = 1'b0;
      #40;
    end
  end

  always @(posedge bus_if.adc_clk) adc_cnt <= adc_cnt + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_write(output int start);
    @(negedge clk);
    bus_if.cs_n = 1'b0;
    bus_if.wr_n = 1'b0;
    repeat (4) @(negedge clk);
    check_val("arm_busy", 32'(bus_if.busy), 32'd1);
    check_val("arm_intr_n", 32'(bus_if.intr_n), 32'd1);
    @(posedge bus_if.adc_clk);
    #1;
    bus_if.wr_n = 1'b1;
    start = adc_cnt;
    repeat (2) @(negedge clk);
    bus_if.cs_n = 1'b1;
  endtask

  task automatic do_read(input string tag);
    @(negedge clk);
    bus_if.cs_n = 1'b0;
    bus_if.rd_n = 1'b0;
    repeat (4) @(negedge clk);
    check_val({tag, "_oe"}, 32'(bus_if.data_oe), 32'd1);
    check_val({tag, "_data"}, 32'(bus_if.data_out), 32'(m_result));
    check_val({tag, "_intr_n"}, 32'(bus_if.intr_n), 32'd1);
    repeat (16) @(negedge clk);
    bus_if.rd_n = 1'b1;
    bus_if.cs_n = 1'b1;
    repeat (4) @(negedge clk);
    check_val({tag, "_oe_off"}, 32'(bus_if.data_oe), 32'd0);
    check_val({tag, "_data_hold"}, 32'(bus_if.data_out), 32'(m_result));
  endtask

  // Full conversion, optionally restarted after abort_at adc_clk edges
  task automatic run_conversion(input int abort_at);
    int start;
    logic [DW-1:0] latched;
    latched = DW'($urandom);
    bus_if.sample_in = latched;
    start_write(start);
    if (abort_at > 0) begin
      wait (adc_cnt == start + abort_at);
      check_val("abort_busy", 32'(bus_if.busy), 32'd1);
      check_val("abort_intr_n", 32'(bus_if.intr_n), 32'd1);
      latched = DW'($urandom);
      bus_if.sample_in = latched;
      start_write(start);
    end
    wait (adc_cnt == start + 10);
    bus_if.sample_in = ~latched;
    do_read("mid");
    wait (adc_cnt == start + CONV);
    #1;
    check_val("pre_done_busy", 32'(bus_if.busy), 32'd1);
    check_val("pre_done_intr_n", 32'(bus_if.intr_n), 32'd1);
    repeat (5) @(negedge clk);
    check_val("done_intr_n", 32'(bus_if.intr_n), 32'd0);
    check_val("done_busy", 32'(bus_if.busy), 32'd0);
    m_result = latched;
    do_read("post");
  endtask

  task automatic reset_mid();
    int start;
    int k;
    bus_if.sample_in = DW'($urandom);
    start_write(start);
    k = $urandom_range(5, 60);
    wait (adc_cnt == start + k);
    #7;
    rst_n = 1'b0;
    #1;
    check_val("rst_intr_n", 32'(bus_if.intr_n), 32'd1);
    check_val("rst_oe", 32'(bus_if.data_oe), 32'd0);
    check_val("rst_busy", 32'(bus_if.busy), 32'd0);
    check_val("rst_data", 32'(bus_if.data_out), 32'd0);
    m_result = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait (adc_cnt == start + k + 80);
    #1;
    check_val("post_rst_intr_n", 32'(bus_if.intr_n), 32'd1);
    check_val("post_rst_busy", 32'(bus_if.busy), 32'd0);
  endtask

  task automatic cs_abort();
    int s;
    @(negedge clk);
    bus_if.sample_in = DW'($urandom);
    bus_if.cs_n = 1'b0;
    bus_if.wr_n = 1'b0;
    repeat (4) @(negedge clk);
    check_val("csab_arm_busy", 32'(bus_if.busy), 32'd1);
    bus_if.cs_n = 1'b1;
    repeat (4) @(negedge clk);
    check_val("csab_busy", 32'(bus_if.busy), 32'd0);
    check_val("csab_intr_n", 32'(bus_if.intr_n), 32'd1);
    bus_if.wr_n = 1'b1;
    s = adc_cnt;
    wait (adc_cnt == s + 40);
    #1;
    check_val("csab_idle_intr_n", 32'(bus_if.intr_n), 32'd1);
    check_val("csab_idle_busy", 32'(bus_if.busy), 32'd0);
    do_read("csab");
  endtask

  initial begin
    int op;
    rst_n            = 1'b0;
    bus_if.cs_n      = 1'b1;
    bus_if.wr_n      = 1'b1;
    bus_if.rd_n      = 1'b1;
    bus_if.sample_in = '0;
    m_result         = '0;
    repeat (3) @(negedge clk);
    check_val("reset_intr_n", 32'(bus_if.intr_n), 32'd1);
    check_val("reset_oe", 32'(bus_if.data_oe), 32'd0);
    check_val("reset_busy", 32'(bus_if.busy), 32'd0);
    check_val("reset_data", 32'(bus_if.data_out), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_val("idle_intr_n", 32'(bus_if.intr_n), 32'd1);
    check_val("idle_busy", 32'(bus_if.busy), 32'd0);

    for (int i = 0; i < 12; i++) begin
      op = (i < 5) ? i : int'($urandom_range(0, 4));
      case (op)
        0:       run_conversion(0);
        1:       do_read("rd");
        2:       run_conversion(int'($urandom_range(5, 40)));
        3:       reset_mid();
        default: cs_abort();
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc0804_responder.md
Name: adc0804_responder

Overview:
- Synthesizable model of the ADC0804-class converter: the device side of the cs_n/wr_n/rd_n/intr_n parallel ADC handshake that our ADC controller drives.
- Used for FPGA loopback and bench closure. Placed opposite the controller, it accepts the controller's start pulse and conversion clock, converts a digital stand-in for the analog input, asserts intr_n, and drives data on read.

Parameters:
- DATA_W, 8, width of sample_in / data_out
- CONV_CYCLES, 64, adc_clk rising edges per conversion (range 2..255)
- SYNC_STAGES, 2, flops per input synchronizer (minimum 2)

Ports:
- clk  input  1  system clock; must be at least 4x the adc_clk frequency
- rst_n  input  1  reset; asynchronous, active-low
- cs_n  input  1  chip select from controller, active-low
- wr_n  input  1  start-conversion strobe, active-low
- rd_n  input  1  read strobe, active-low
- adc_clk  input  1  conversion clock from controller; sampled as data, not used as a clock
- sample_in  input  DATA_W  analog stand-in value
- intr_n  output  1  end-of-conversion flag, active-low
- data_out  output  DATA_W  conversion result
- data_oe  output  1  data_out valid / bus-drive enable
- busy  output  1  high while a conversion is in progress

Behaviour:
- Reset (async, rst_n=0): intr_n=1, data_out=0, data_oe=0, busy=0, state IDLE, counter=0, result=0, all synchronizer flops set to their inactive levels (1 for strobes, 0 for adc_clk).
- Input synchronization: cs_n, wr_n, rd_n and adc_clk each pass through SYNC_STAGES flops, then one edge-detect register.
- Edge latency: a pin change is acted on SYNC_STAGES+1 clk cycles later (3 cycles by default).
- Write window: wr_n low while cs_n low (both synchronized).
- Read window: rd_n low while cs_n low (both synchronized).
- State machine IDLE / ARMED / CONVERT / DONE:
  - IDLE or DONE -> ARMED when the write window opens: intr_n<=1, busy<=1.
  - ARMED -> CONVERT on the wr_n rising edge (write window closing): sample_in is latched into the hold register, counter<=0.
  - ARMED -> IDLE if cs_n rises before wr_n rises. No conversion; intr_n stays 1; busy<=0.
  - CONVERT: counter increments on each synchronized adc_clk rising edge.
  - CONVERT -> DONE the clk after counter reaches CONV_CYCLES: result<=hold, intr_n<=0, busy<=0.
  - CONVERT -> ARMED if the write window opens again. The conversion is aborted, counter is cleared, and the previous result is kept.
- Read output:
  - data_oe=1 and data_out=result on every clk the read window is open, in any state. data_out holds its value when the read window closes; data_oe<=0.
  - The read window opening sets intr_n<=1.
- Simultaneous events:
  - Completion in the same cycle as an open read window: result updates, intr_n<=0 anyway. The next read clears it.
  - Read window and write window together: the write wins (state -> ARMED, intr_n=1). data_oe still follows the read window.
- adc_clk stopped: CONVERT holds indefinitely with no timeout. busy stays 1.
- Reset mid-conversion: immediate return to reset values. No partial result is ever written.
- Width rules:
  - counter is 8 bits and does not wrap; it saturates at CONV_CYCLES.
  - result is exactly DATA_W bits, with no arithmetic on the sample.

Decomposition:
- Shared header adc_if_defs.vh, also included by the controller:
  - state encodings IDLE=2'd0, ARMED=2'd1, CONVERT=2'd2, DONE=2'd3
  - default DATA_W and CONV_CYCLES
  - SYNC_STAGES minimum
- One sub-module, sync_ff (parameterized depth and reset value), instantiated four times. The FSM, counter and result path stay in the top.

Test Plan:
- Basic conversion (clk 10 ns, adc_clk 640 ns, sample_in=8'h0A): pulse cs_n/wr_n low for 100 ns -> intr_n=1 within 3 clk of the falling edge. intr_n falls about 64 adc_clk edges (~41 us) after wr_n rises. busy falls on that same cycle.
- Read: after intr_n=0, hold cs_n=rd_n=0 for 200 ns -> data_oe=1 and data_out=8'h0A within 3 clk. intr_n=1 by the next clk. data_oe=0 within 3 clk of rd_n rising.
- Sample-at-start: latch 8'h0A, then change sample_in to 8'hF3 mid-conversion -> read returns 8'h0A. A second conversion returns 8'hF3.
- Restart abort: issue a second write pulse after 20 adc_clk edges -> intr_n stays 1 and the count restarts. intr_n falls 64 edges after the second wr_n rising edge. The prior result is unchanged until then.
- Async reset mid-conversion: drop rst_n at edge 30 -> intr_n=1, data_oe=0, busy=0 immediately. After release, with no write, intr_n never falls.
- cs_n abort: wr_n low then cs_n high before wr_n rises -> state IDLE, busy=0, no conversion, intr_n stays 1 for 100 us.
